// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter_if
// Brief    : Requester-side and memory-wrapper-side signal bundle for the
//            multi-channel memory request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_req_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 64
);
  localparam int c_id_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*2-1:0]      ch_width;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_err;
  logic [DATA_W-1:0]        rdata;
  logic [c_id_w-1:0]        grant_id;
  logic                     busy;

  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [1:0]               mem_width;
  logic                     mem_wstrobe;
  logic                     mem_rstrobe;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_ready;
  logic                     mem_complete;

  // The arbiter itself
  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata, ch_width,
    input  mem_rdata, mem_ready, mem_complete,
    output ch_ack, ch_err, rdata, grant_id, busy,
    output mem_addr, mem_wdata, mem_width, mem_wstrobe, mem_rstrobe
  );

  // Requesters plus memory wrapper, seen from the outside
  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata, ch_width,
    output mem_rdata, mem_ready, mem_complete,
    input  ch_ack, ch_err, rdata, grant_id, busy,
    input  mem_addr, mem_wdata, mem_width, mem_wstrobe, mem_rstrobe
  );
endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Brief    : Round-robin front end issuing one memory strobe per granted
//            channel request, with completion timeout and per-channel ack/err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk_cpu,
  input  logic             rst_n,
  mem_req_arbiter_if.slave bus
);
  localparam int c_id_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_id_w-1:0]   rr_q, rr_d;
  logic [c_id_w-1:0]   gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                we_q, we_d;
  logic                ok_q, ok_d;
  logic                wstb_q, wstb_d;
  logic                rstb_q, rstb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          width_q, width_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;

  logic                w_found;
  logic [c_id_w-1:0]   w_pick;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [1:0]          w_width;
  logic [NUM_CH-1:0]   w_ack;
  logic [NUM_CH-1:0]   w_err;

  // Pass 0 covers channels above the pointer, pass 1 wraps around to it.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_width = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_found && bus.ch_req[i] &&
            ((p == 0) ? (i > int'(rr_q)) : (i <= int'(rr_q)))) begin
          w_found = 1'b1;
          w_pick  = c_id_w'(i);
          w_we    = bus.ch_we[i];
          w_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
          w_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
          w_width = bus.ch_width[i*2 +: 2];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    we_d    = we_q;
    ok_d    = ok_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    wstb_d  = 1'b0;
    rstb_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_found) begin
          gnt_d   = w_pick;
          rr_d    = w_pick;
          busy_d  = 1'b1;
          we_d    = w_we;
          addr_d  = w_addr;
          wdata_d = w_wdata;
          width_d = w_width;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mem_ready) begin
          wstb_d  = we_q;
          rstb_d  = !we_q;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion wins over a timeout landing on the same cycle.
        if (bus.mem_complete) begin
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          ok_d    = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == c_cnt_w'(TIMEOUT)) begin
          ok_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= c_id_w'(NUM_CH - 1);
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      wstb_q  <= 1'b0;
      rstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      ok_q    <= ok_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      wstb_q  <= wstb_d;
      rstb_q  <= rstb_d;
    end
  end

  // Response pulses are decoded from flops only, so they are glitch-free.
  always_comb begin
    w_ack = '0;
    w_err = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ack[i] = (state_q == S_RESP) &&  ok_q && (gnt_q == c_id_w'(i));
      w_err[i] = (state_q == S_RESP) && !ok_q && (gnt_q == c_id_w'(i));
    end
  end

  assign bus.ch_ack      = w_ack;
  assign bus.ch_err      = w_err;
  assign bus.rdata       = rdata_q;
  assign bus.grant_id    = gnt_q;
  assign bus.busy        = busy_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_width   = width_q;
  assign bus.mem_wstrobe = wstb_q;
  assign bus.mem_rstrobe = rstb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a round-robin transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 28;
  localparam int DW  = 64;
  localparam int TO  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_cpu (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] cur_rdata;
  int last_g;

  typedef struct {
    int            ch;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    width;
    int            rdy;
    int            cmp;
    logic [DW-1:0] rdval;
    bit            drop;
    bit            exp_ok;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic raise(input int c, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] w);
    bus.ch_req[c]             = 1'b1;
    bus.ch_we[c]              = we;
    bus.ch_addr[c*AW +: AW]   = a;
    bus.ch_wdata[c*DW +: DW]  = d;
    bus.ch_width[c*2 +: 2]    = w;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    64'(bus.busy), 64'd0);
    chk({tag, "_grant"},   64'(bus.grant_id), 64'd0);
    chk({tag, "_ack"},     64'(bus.ch_ack), 64'd0);
    chk({tag, "_err"},     64'(bus.ch_err), 64'd0);
    chk({tag, "_rdata"},   bus.rdata, 64'd0);
    chk({tag, "_maddr"},   64'(bus.mem_addr), 64'd0);
    chk({tag, "_mwdata"},  bus.mem_wdata, 64'd0);
    chk({tag, "_mwidth"},  64'(bus.mem_width), 64'd0);
    chk({tag, "_wstb"},    64'(bus.mem_wstrobe), 64'd0);
    chk({tag, "_rstb"},    64'(bus.mem_rstrobe), 64'd0);
  endtask

  // Entered at a negedge in IDLE with the requests already driven; leaves at
  // the negedge of the IDLE cycle following the response pulse.
  task automatic run_txn(input string tag, input int ch, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [1:0] width, input int rdy, input int cmp,
                         input logic [DW-1:0] rdval, input bit drop,
                         input bit exp_ok, input logic [DW-1:0] exp_rdata);
    int lat;
    bit seen, extra, early;
    logic [NCH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    bus.mem_ready    = 1'b0;
    bus.mem_complete = 1'b0;
    bus.mem_rdata    = rdval;
    @(negedge clk);
    chk({tag, "_busy_on_grant"}, 64'(bus.busy), 64'd1);
    chk({tag, "_grant_id"}, 64'(bus.grant_id), 64'(ch));
    if (drop) begin
      bus.ch_req[ch]            = 1'b0;
      bus.ch_addr[ch*AW +: AW]  = 28'h0FFFFFF;
      bus.ch_wdata[ch*DW +: DW] = ~wdata;
      bus.ch_we[ch]             = ~we;
    end
    early = 1'b0;
    for (int i = 0; i < rdy; i++) begin
      @(negedge clk);
      if (bus.mem_wstrobe || bus.mem_rstrobe || (bus.ch_err != '0)) early = 1'b1;
    end
    if (rdy > 0) chk({tag, "_quiet_while_not_ready"}, 64'(early), 64'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk({tag, "_wstrobe"}, 64'(bus.mem_wstrobe), 64'(we));
    chk({tag, "_rstrobe"}, 64'(bus.mem_rstrobe), 64'(!we));
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(addr));
    chk({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
    chk({tag, "_mem_width"}, 64'(bus.mem_width), 64'(width));
    lat = 0;
    seen = 1'b0;
    extra = 1'b0;
    while (!seen && lat < 40) begin
      bus.mem_complete = (lat == cmp);
      @(negedge clk);
      lat++;
      if (bus.mem_wstrobe || bus.mem_rstrobe) extra = 1'b1;
      if ((bus.ch_ack != '0) || (bus.ch_err != '0)) seen = 1'b1;
    end
    bus.mem_complete = 1'b0;
    chk({tag, "_resp_seen"}, 64'(seen), 64'd1);
    chk({tag, "_resp_latency"}, 64'(lat), exp_ok ? 64'(cmp + 1) : 64'(TO + 1));
    chk({tag, "_ack"}, 64'(bus.ch_ack), exp_ok ? 64'(m) : 64'd0);
    chk({tag, "_err"}, 64'(bus.ch_err), exp_ok ? 64'd0 : 64'(m));
    chk({tag, "_rdata"}, bus.rdata, exp_rdata);
    chk({tag, "_single_strobe"}, 64'(extra), 64'd0);
    bus.ch_req[ch] = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, 64'(bus.ch_ack | bus.ch_err), 64'd0);
    chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int g[$];
    int nstb, nacks, exp_g, rdy, cmp;
    bit prev_busy, prev_ack, overlap, ackbad, bad, we, drop, ok;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rv, er;
    logic [1:0] w;

    vt[0] = '{0, 1'b1, 28'h0000100, 64'hDEADBEEF_01234567, 2'd3, 0,  2, 64'h0, 1'b0, 1'b1, 64'h0};
    vt[1] = '{0, 1'b0, 28'h0000100, 64'h0, 2'd3, 0,  0, 64'hDEADBEEF_01234567, 1'b0, 1'b1, 64'hDEADBEEF_01234567};
    vt[2] = '{1, 1'b1, 28'h0000200, 64'h11112222_33334444, 2'd1, 50, 3, 64'h99999999_99999999, 1'b0, 1'b1, 64'hDEADBEEF_01234567};
    vt[3] = '{3, 1'b0, 28'h0000300, 64'h0, 2'd2, 1, -1, 64'h5A5A5A5A_5A5A5A5A, 1'b0, 1'b0, 64'hDEADBEEF_01234567};
    vt[4] = '{2, 1'b0, 28'h0000ABC, 64'h0, 2'd0, 0,  1, 64'hCAFEF00D_12345678, 1'b1, 1'b1, 64'hCAFEF00D_12345678};
    vt[5] = '{1, 1'b0, 28'h0000400, 64'h0, 2'd3, 2, 15, 64'h5555, 1'b0, 1'b1, 64'h5555};
    vt[6] = '{0, 1'b0, 28'h0000500, 64'h0, 2'd3, 0, 16, 64'h7777, 1'b0, 1'b0, 64'h5555};
    vt[7] = '{3, 1'b1, 28'h0FFFFFF, 64'hFFFFFFFF_FFFFFFFF, 2'd2, 0, 5, 64'h8888, 1'b0, 1'b1, 64'h5555};

    bus.ch_req = '0;       bus.ch_we = '0;       bus.ch_addr = '0;
    bus.ch_wdata = '0;     bus.ch_width = '0;    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;  bus.mem_complete = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    cur_rdata = '0;

    for (int i = 0; i < 8; i++) begin
      raise(vt[i].ch, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].width);
      run_txn($sformatf("vec%0d", i), vt[i].ch, vt[i].we, vt[i].addr, vt[i].wdata,
              vt[i].width, vt[i].rdy, vt[i].cmp, vt[i].rdval, vt[i].drop,
              vt[i].exp_ok, vt[i].exp_rdata);
      cur_rdata = vt[i].exp_rdata;
    end

    // Timeout followed by a late completion arriving in IDLE
    raise(2, 1'b0, 28'h0000600, 64'h0, 2'd1);
    run_txn("stray_to", 2, 1'b0, 28'h0000600, 64'h0, 2'd1, 0, -1, 64'hABAB, 1'b0, 1'b0, cur_rdata);
    bus.mem_rdata = 64'hBAD0BAD0_BAD0BAD0;
    bus.mem_complete = 1'b1;
    bus.mem_ready = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if ((bus.ch_ack != '0) || (bus.ch_err != '0) || bus.busy ||
          bus.mem_wstrobe || bus.mem_rstrobe) bad = 1'b1;
    end
    bus.mem_complete = 1'b0;
    bus.mem_ready = 1'b0;
    chk("stray_ignored", 64'(bad), 64'd0);
    chk("stray_rdata", bus.rdata, cur_rdata);

    // Round robin with all four channels held
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    raise(0, 1'b1, 28'h0000010, 64'hA0, 2'd3);
    raise(1, 1'b0, 28'h0000020, 64'hA1, 2'd3);
    raise(2, 1'b1, 28'h0000030, 64'hA2, 2'd3);
    raise(3, 1'b0, 28'h0000040, 64'hA3, 2'd3);
    bus.mem_rdata = 64'h01234567_89ABCDEF;
    bus.mem_ready = 1'b1;
    bus.mem_complete = 1'b1;
    prev_busy = 1'b0; prev_ack = 1'b0; overlap = 1'b0; ackbad = 1'b0;
    nstb = 0; nacks = 0;
    for (int cyc = 0; cyc < 60 && g.size() < 5; cyc++) begin
      @(negedge clk);
      if (bus.busy && !prev_busy) g.push_back(int'(bus.grant_id));
      if (bus.mem_wstrobe && bus.mem_rstrobe) overlap = 1'b1;
      if (bus.mem_wstrobe || bus.mem_rstrobe) nstb++;
      if (bus.ch_ack != '0) begin
        nacks++;
        if ((bus.ch_ack != (NCH'(1) << bus.grant_id)) || prev_ack) ackbad = 1'b1;
      end
      prev_ack  = (bus.ch_ack != '0);
      prev_busy = bus.busy;
    end
    chk("rr_grant_count", 64'(g.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_grant%0d", i), 64'((g.size() > i) ? g[i] : -1), 64'(i % NCH));
    chk("rr_strobes", 64'(nstb), 64'd4);
    chk("rr_acks", 64'(nacks), 64'd4);
    chk("rr_no_overlap", 64'(overlap), 64'd0);
    chk("rr_ack_onehot_pulse", 64'(ackbad), 64'd0);
    bus.ch_req = '0;
    bad = 1'b1;
    for (int cyc = 0; cyc < 10 && bad; cyc++) begin
      @(negedge clk);
      if (!bus.busy) bad = 1'b0;
    end
    chk("rr_drain", 64'(bad), 64'd0);
    bus.mem_ready = 1'b0;
    bus.mem_complete = 1'b0;
    chk("rr_rdata", bus.rdata, 64'h01234567_89ABCDEF);

    // Reset in the middle of WAIT
    raise(0, 1'b0, 28'h0000700, 64'h0, 2'd3);
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    bus.ch_req[0] = 1'b0;
    raise(1, 1'b0, 28'h0000800, 64'h0, 2'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("after_reset", 1, 1'b0, 28'h0000800, 64'h0, 2'd1, 0, 2, 64'h0F0F0F0F_F0F0F0F0,
            1'b0, 1'b1, 64'h0F0F0F0F_F0F0F0F0);
    cur_rdata = 64'h0F0F0F0F_F0F0F0F0;
    last_g = 1;

    // Randomized traffic against the round-robin transaction model
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < NCH; c++)
        if (!bus.ch_req[c] && $urandom_range(0, 2) == 0)
          raise(c, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      if (bus.ch_req == '0)
        raise(int'($urandom_range(0, NCH - 1)), 1'($urandom_range(0, 1)), AW'($urandom),
              {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      exp_g = -1;
      for (int k = 1; k <= NCH; k++)
        if (exp_g < 0 && bus.ch_req[(last_g + k) % NCH]) exp_g = (last_g + k) % NCH;
      we   = bus.ch_we[exp_g];
      a    = bus.ch_addr[exp_g*AW +: AW];
      d    = bus.ch_wdata[exp_g*DW +: DW];
      w    = bus.ch_width[exp_g*2 +: 2];
      rdy  = int'($urandom_range(0, 3));
      cmp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 5));
      drop = ($urandom_range(0, 3) == 0);
      rv   = {$urandom, $urandom};
      ok   = (cmp <= TO);
      er   = (ok && !we) ? rv : cur_rdata;
      run_txn($sformatf("rnd%0d", t), exp_g, we, a, d, w, rdy, cmp, rv, drop, ok, er);
      cur_rdata = er;
      last_g = exp_g;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Multi-channel request front end for the DDR2 memory wrapper (mem_example), in the clk_cpu domain.
- Generalises the single-requester write/read sequencer to NUM_CH independent requesters with round-robin arbitration.
- Each granted transaction is issued to the memory wrapper as exactly one strobe.
- Adds per-transaction timeout detection and per-channel completion/error signalling.

Parameters:
NUM_CH, 2, number of requesting channels (2..8)
ADDR_W, 28, byte address width
DATA_W, 64, data width
TIMEOUT, 4095, clk_cpu cycles to wait for mem_transaction_complete before aborting (>=1)

Ports:
clk_cpu  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel request, level; held until ch_ack or ch_err
ch_we  in  NUM_CH  1=write, 0=read
ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*DATA_W  packed write data
ch_width  in  NUM_CH*2  packed transaction width codes (RAM_WIDTH* encoding)
ch_ack  out  NUM_CH  one-cycle pulse: granted transaction completed
ch_err  out  NUM_CH  one-cycle pulse: granted transaction timed out
rdata  out  DATA_W  read data of last completed read; valid when ch_ack of a read pulses
grant_id  out  clog2(NUM_CH) (min 1)  channel currently/last granted
busy  out  1  high from grant until ack/err
mem_addr  out  ADDR_W  to wrapper addr
mem_wdata  out  DATA_W  to wrapper data_in
mem_width  out  2  to wrapper width
mem_wstrobe  out  1  one-cycle write strobe
mem_rstrobe  out  1  one-cycle read strobe
mem_rdata  in  DATA_W  from wrapper data_out
mem_ready  in  1  wrapper ready
mem_complete  in  1  wrapper transaction_complete

Behaviour:
- Reset (async, rst_n=0): all outputs 0.
  - State IDLE, rr pointer = NUM_CH-1, so channel 0 wins first.
  - Timeout counter 0.
  - Reset mid-transaction abandons the transaction; no ack or err is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any ch_req is set, grant the first requesting channel searching upward from rr+1, modulo NUM_CH.
  - Latch ch_we/addr/wdata/width of the granted channel into mem_addr/mem_wdata/mem_width and an internal we flag.
  - grant_id <= channel; rr <= channel; busy <= 1; go to ISSUE.
  - Grant decision takes 1 cycle after req is sampled.
- ISSUE:
  - When mem_ready=1, assert mem_wstrobe (we=1) or mem_rstrobe (we=0) for exactly one cycle, clear the counter, go to WAIT.
  - While mem_ready=0, hold. No timeout applies in ISSUE.
- WAIT:
  - Strobes are 0. The counter increments each cycle.
  - If mem_complete=1: when a read, rdata <= mem_rdata; go to RESP with status ok.
  - Else if counter == TIMEOUT: go to RESP with status err.
  - mem_complete on the same cycle the counter reaches TIMEOUT counts as complete (ok).
- RESP:
  - Pulse ch_ack[grant_id] (ok) or ch_err[grant_id] (err) for one cycle; busy <= 0; go to IDLE.
  - The minimum spacing between grants is therefore 4 cycles, which gives requesters a cycle to drop ch_req after ack.
- Latched request fields are stable from grant to RESP. Changes on ch_* inputs after grant are ignored.
- If ch_req drops after grant, the transaction still completes and the ack/err still pulses.
- mem_complete or mem_ready while not in the corresponding state is ignored.
- rdata is unchanged by writes and by errors.
- A channel holding ch_req continuously is re-granted only after all other requesting channels have been served (fairness bound: NUM_CH-1 intervening grants).
- Late completion after a timeout: a stray mem_complete arriving in IDLE/ISSUE is ignored.

Test Plan:
- Single write then read, ch0: addr=0x0000100, wdata=0xDEADBEEF_01234567, we=1, then we=0 -> one mem_wstrobe, then one mem_rstrobe; ch_ack[0] pulses twice; rdata=0xDEADBEEF_01234567.
- Round-robin, NUM_CH=4: all four ch_req held high -> grant_id sequence 0,1,2,3,0; each ch_ack one cycle; no overlap of strobes.
- mem_ready held low 50 cycles after grant -> no strobe and no err for 50 cycles; strobe occurs on the first cycle ready=1.
- Timeout, TIMEOUT=15: mem_complete never asserted -> ch_err[grant_id] pulses 16 cycles after the strobe, ch_ack stays 0, rdata unchanged. A later mem_complete is ignored.
- ch_req[2] dropped the cycle after grant, with ch_addr changed to 0x0FFFFFF -> transaction uses the original address, and ch_ack[2] still pulses.
- rst_n asserted mid-WAIT -> all outputs 0 immediately. After release with ch_req[1] high, grant_id=1 is issued cleanly and no stale ack appears.
